// File: rtl/hazard_scoreboard_unit.sv
// RAW hazard scoreboard at decode: tracks the last DEPTH destinations and stalls on a source match.
// Define HAZARD_FWD_EN to stall only on load-use against the youngest entry (forwarding build).
module hsu_slot_match #(
  parameter int  REG_ADDR_W = 5,
  parameter bit  LOAD_ONLY  = 1'b0
) (
  input  logic                  valid,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  load,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  hit
);
  logic src_hit;
  assign src_hit = ((rs == dest) && (rs != '0)) || ((rt == dest) && (rt != '0));
  assign hit     = valid && src_hit && (!LOAD_ONLY || load);
endmodule

module hazard_scoreboard_unit #(
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 16
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               writes_reg,
  input  logic               dest_sel,
  input  logic               is_load,
  input  logic               flush,
  output logic               Control,
  output logic               PC,
  output logic [CNT_W-1:0]   stall_count
);
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int LEN_W = $clog2(DEPTH + 2);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  load;
  } entry_t;

  typedef enum logic {RUN, STALL} state_t;

  entry_t [DEPTH-1:0]    slot;
  logic   [DEPTH-1:0]    hit;
  logic   [DEPTH-1:0]    hit_mask;
  logic [REG_ADDR_W-1:0] rs, rt, rd, dest;
  logic                  hazard;
  logic                  unused_fields;
  state_t                state, state_next;
  logic [LEN_W-1:0]      stall_len, stall_len_next;

  assign rs            = instruction[25:21];
  assign rt            = instruction[20:16];
  assign rd            = instruction[15:11];
  assign dest          = dest_sel ? rd : rt;
  assign unused_fields = ^instruction;

  // With forwarding only the youngest slot can still need a stall (load-use).
  assign hit_mask = FWD ? DEPTH'(1) : {DEPTH{1'b1}};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    hsu_slot_match #(.REG_ADDR_W(REG_ADDR_W), .LOAD_ONLY(FWD)) u_match (
      .valid (slot[g].valid),
      .dest  (slot[g].dest),
      .load  (slot[g].load),
      .rs    (rs),
      .rt    (rt),
      .hit   (hit[g])
    );
  end

  assign hazard  = instr_valid && !flush && |(hit & hit_mask);
  assign Control = !hazard;
  assign PC      = hazard;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      slot <= '0;
    end else if (flush) begin
      slot <= '0;
    end else begin
      slot[0].valid <= instr_valid && writes_reg && (dest != '0) && !hazard;
      slot[0].dest  <= dest;
      slot[0].load  <= is_load;
      for (int i = 1; i < DEPTH; i++) slot[i] <= slot[i-1];
    end
  end

  always_comb begin
    state_next     = RUN;
    stall_len_next = '0;
    case (state)
      RUN: begin
        if (hazard) begin
          state_next     = STALL;
          stall_len_next = LEN_W'(1);
        end
      end
      STALL: begin
        if (hazard) begin
          state_next     = STALL;
          stall_len_next = (stall_len == '1) ? stall_len : stall_len + LEN_W'(1);
        end
      end
      default: begin
        state_next     = RUN;
        stall_len_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= RUN;
      stall_len   <= '0;
      stall_count <= '0;
    end else begin
      state     <= state_next;
      stall_len <= stall_len_next;
      if (PC && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: directed vector table, reset/saturation sequences, random vs queue model.
module tb_hazard_scoreboard_unit;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        iv = 1'b0, wr = 1'b0, sel = 1'b0, ld = 1'b0, fl = 1'b0;
  logic [31:0] ins = '0;
  logic        ctl, pc, ctl_s, pc_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .CLOCK(clk), .RESET(rst), .instr_valid(iv), .instruction(ins), .writes_reg(wr),
    .dest_sel(sel), .is_load(ld), .flush(fl), .Control(ctl), .PC(pc), .stall_count(cnt));

  hazard_scoreboard_unit #(.CNT_W(4)) dut_sat (
    .CLOCK(clk), .RESET(rst), .instr_valid(iv), .instruction(ins), .writes_reg(wr),
    .dest_sel(sel), .is_load(ld), .flush(fl), .Control(ctl_s), .PC(pc_s), .stall_count(cnt_s));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: list of the last DEPTH issue records, youngest first.
  typedef struct { bit v; int d; bit ld; } ent_t;
  ent_t hist[$];
  int   mcnt;

  function automatic bit m_hazard();
    int rs, rt;
    logic [31:0] w;
    w  = ins;
    rs = int'(w[25:21]);
    rt = int'(w[20:16]);
    if (!iv || fl) return 1'b0;
    foreach (hist[i]) begin
      if (!hist[i].v) continue;
      if (FWD && (i != 0 || !hist[i].ld)) continue;
      if ((rs != 0 && rs == hist[i].d) || (rt != 0 && rt == hist[i].d)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void m_clear();
    ent_t e;
    e = '{v: 1'b0, d: 0, ld: 1'b0};
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(e);
  endfunction

  task automatic tick();
    bit   h;
    ent_t e;
    logic [31:0] w;
    h = m_hazard();
    w = ins;
    e.d  = sel ? int'(w[15:11]) : int'(w[20:16]);
    e.ld = ld;
    e.v  = iv && wr && (e.d != 0) && !h;
    @(posedge clk);
    if (fl) m_clear();
    else begin
      hist.push_front(e);
      void'(hist.pop_back());
    end
    if (h && mcnt < 65535) mcnt++;
    #1;
  endtask

  task automatic apply(input bit v, input logic [31:0] w, input bit wrr, input bit s,
                       input bit l, input bit f);
    iv = v; ins = w; wr = wrr; sel = s; ld = l; fl = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(0, 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    mcnt = 0;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'h020};
  endfunction
  function automatic logic [31:0] lw(input int rs, input int rt);
    return {6'h23, 5'(rs), 5'(rt), 16'h0};
  endfunction

  typedef struct {
    bit v; logic [31:0] w; bit wr, sel, ld, fl;
    bit pc_b, pc_f; int cnt_b, cnt_f;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit v, input logic [31:0] w, input bit wrr, input bit s,
                      input bit l, input bit f, input bit pb, input bit pf,
                      input int cb, input int cf);
    vec_t e;
    e = '{v: v, w: w, wr: wrr, sel: s, ld: l, fl: f, pc_b: pb, pc_f: pf, cnt_b: cb, cnt_f: cf};
    tbl.push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, run, max_run;
    bit hold, exp_h;

    // RAW chain, r0 exemption, all-zero instructions, flush, load-use, flush beating hazard
    addv(1, rtype(1, 2, 3),  1, 1, 0, 0, 0, 0, 0, 0);
    addv(1, rtype(3, 5, 4),  1, 1, 0, 0, 1, 0, 0, 0);
    addv(1, rtype(3, 5, 4),  1, 1, 0, 0, 1, 0, 1, 0);
    addv(1, rtype(3, 5, 4),  1, 1, 0, 0, 1, 0, 2, 0);
    addv(1, rtype(3, 5, 4),  1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, rtype(1, 2, 0),  1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, rtype(0, 5, 4),  1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, 32'h0,           1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, 32'h0,           1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, rtype(1, 2, 9),  1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, rtype(9, 1, 10), 1, 1, 0, 1, 0, 0, 3, 0);
    addv(1, rtype(9, 1, 10), 1, 1, 0, 0, 0, 0, 3, 0);
    addv(1, lw(1, 7),        1, 0, 1, 0, 0, 0, 3, 0);
    addv(1, rtype(7, 2, 8),  1, 1, 0, 0, 1, 1, 3, 0);
    addv(1, rtype(7, 2, 8),  1, 1, 0, 0, 1, 0, 4, 1);
    addv(1, rtype(7, 2, 8),  1, 1, 0, 0, 1, 0, 5, 1);
    addv(1, rtype(7, 2, 8),  1, 1, 0, 0, 0, 0, 6, 1);
    addv(0, rtype(8, 8, 9),  1, 1, 0, 0, 0, 0, 6, 1);
    addv(1, rtype(1, 2, 7),  1, 1, 0, 0, 0, 0, 6, 1);
    addv(1, rtype(7, 2, 11), 1, 1, 0, 0, 1, 0, 6, 1);
    addv(1, rtype(7, 2, 11), 1, 1, 0, 1, 0, 0, 7, 1);
    addv(1, rtype(7, 2, 11), 1, 1, 0, 0, 0, 0, 7, 1);

    m_clear();
    mcnt = 0;
    #1;
    chk("reset_pc", int'(pc), 0);
    chk("reset_ctl", int'(ctl), 1);
    chk("reset_cnt", int'(cnt), 0);
    do_reset();

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].w, tbl[i].wr, tbl[i].sel, tbl[i].ld, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d_pc", i), int'(pc), int'(FWD ? tbl[i].pc_f : tbl[i].pc_b));
      chk($sformatf("vec%0d_ctl", i), int'(ctl), int'(FWD ? !tbl[i].pc_f : !tbl[i].pc_b));
      chk($sformatf("vec%0d_cnt", i), int'(cnt), FWD ? tbl[i].cnt_f : tbl[i].cnt_b);
      tick();
    end
    apply(0, 32'h0, 0, 0, 0, 0);
    #1;
    chk("table_final_cnt", int'(cnt), FWD ? 1 : 7);

    // Reset asserted in the middle of a load-use stall
    apply(1, lw(1, 7), 1, 0, 1, 0);
    tick();
    apply(1, rtype(7, 2, 8), 1, 1, 0, 0);
    #1;
    chk("midstall_pc", int'(pc), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_pc", int'(pc), 0);
    chk("rst_mid_ctl", int'(ctl), 1);
    chk("rst_mid_cnt", int'(cnt), 0);
    chk("rst_mid_cnt_sat", int'(cnt_s), 0);
    do_reset();

    // Saturation: repeated load-use pairs, every stall held until it clears
    for (int k = 0; k < 24; k++) begin
      apply(1, lw(1, 7), 1, 0, 1, 0);
      tick();
      apply(1, rtype(7, 2, 8), 1, 1, 0, 0);
      #1;
      guard = 0;
      while (pc && guard < 10) begin
        tick();
        guard++;
      end
      if (guard >= 10) chk("stall_bound_expired", guard, 0);
      tick();
    end
    apply(0, 32'h0, 0, 0, 0, 0);
    #1;
    chk("sat_main_cnt", int'(cnt), FWD ? 24 : 72);
    chk("sat_cnt4", int'(cnt_s), 15);

    // Random traffic vs the queue model; stalled instructions are usually re-presented
    hold = 0; run = 0; max_run = 0;
    for (int k = 0; k < 500; k++) begin
      if (!hold) begin
        apply($urandom_range(0, 7) != 0,
              {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)},
              $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'b0);
      end
      fl = ($urandom_range(0, 11) == 0);
      #1;
      exp_h = m_hazard();
      chk("rnd_pc", int'(pc), int'(exp_h));
      chk("rnd_ctl", int'(ctl), int'(!exp_h));
      chk("rnd_cnt", int'(cnt), mcnt);
      chk("rnd_cnt_sat", int'(cnt_s), (mcnt > 15) ? 15 : mcnt);
      run = pc ? run + 1 : 0;
      if (run > max_run) max_run = run;
      hold = exp_h && ($urandom_range(0, 3) != 0);
      tick();
    end
    chk("max_stall_run_ok", int'(max_run <= (FWD ? 1 : DEPTH)), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
